prco_reg_arb: RTL and testbench

PRCO_REG_ARB -- requirements
Module: prco_reg_arb

---
 rtl/prco_reg_arb.sv | 143 ++++++++++++++
 tb/tb_prco_reg_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_reg_arb.sv
// prco_reg_arb: round-robin arbiter for the single register-file write port, shared by
// three requesters (0 = ALU, 1 = memory unit, 2 = debug). It can optionally include an
// issue-stage scoreboard that tracks registers with a pending write.
//
// Optional feature macro: PRCO_ARB_SCOREBOARD_EN. When it is defined, the scoreboard
// drives q_busy and q_stall. When it is undefined, q_busy = 0, q_stall = 0, and the claim
// inputs are ignored.
//
// Ports:
//   i_clk        clock; all state changes on posedge
//   i_reset      asynchronous, active-high reset
//   i_en         clock enable; low holds state and forces q_gnt/q_we to zero at the next edge
//   i_req[2:0]   write request, one bit per requester
//   i_sel0..2    destination register index, one per requester
//   i_dat0..2    write data, one per requester
//   q_gnt[2:0]   registered one-hot grant pulse
//   q_we         register-file write enable (single-cycle pulse)
//   q_seld       register-file destination select (held when idle)
//   q_datd       register-file write data (held when idle)
//   i_claim      issue-stage claim of a destination register
//   i_claim_sel  index of the claimed register
//   q_busy[7:0]  per-register pending-write mask
//   q_stall      combinational stall: the claim targets a busy register
module prco_reg_arb (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_sel0,
    input  logic [2:0]  i_sel1,
    input  logic [2:0]  i_sel2,
    input  logic [15:0] i_dat0,
    input  logic [15:0] i_dat1,
    input  logic [15:0] i_dat2,
    output logic [2:0]  q_gnt,
    output logic        q_we,
    output logic [2:0]  q_seld,
    output logic [15:0] q_datd,
    input  logic        i_claim,
    input  logic [2:0]  i_claim_sel,
    output logic [7:0]  q_busy,
    output logic        q_stall
);

    logic [1:0]  r_last;
    logic [2:0]  elig;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic [2:0]  win_sel;
    logic [15:0] win_dat;

    // A requester granted on the previous edge is still holding i_req this cycle.
    // Masking it here prevents a second grant for the same request.
    assign elig = i_req & ~q_gnt;

    // Search order is r_last+1, r_last+2, r_last+3 (mod 3). The first eligible
    // requester in that order wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = (r_last >= 2'd2) ? 2'd0 : r_last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    always_comb begin
        win_sel = i_sel0;
        win_dat = i_dat0;
        case (win_idx)
            2'd1: begin
                win_sel = i_sel1;
                win_dat = i_dat1;
            end
            2'd2: begin
                win_sel = i_sel2;
                win_dat = i_dat2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_gnt  <= 3'b000;
            q_we   <= 1'b0;
            q_seld <= 3'd0;
            q_datd <= 16'h0000;
            r_last <= 2'd2;
        end else if (i_en) begin
            q_we <= win_vld;
            if (win_vld) begin
                q_gnt  <= 3'b001 << win_idx;
                q_seld <= win_sel;
                q_datd <= win_dat;
                r_last <= win_idx;
            end else begin
                q_gnt <= 3'b000;
            end
        end else begin
            q_gnt <= 3'b000;
            q_we  <= 1'b0;
        end
    end

`ifdef PRCO_ARB_SCOREBOARD_EN
    logic [7:0] busy_q;
    logic [7:0] busy_d;
    logic [7:0] busy_clr;
    logic [7:0] busy_set;

    assign q_stall = i_claim & busy_q[i_claim_sel];

    // A write visible on q_we retires its destination at the next edge.
    // The clear is applied before the set, so a same-edge claim of that register keeps it busy.
    always_comb begin
        busy_clr = q_we ? (8'h01 << q_seld) : 8'h00;
        busy_set = (i_claim && !q_stall) ? (8'h01 << i_claim_sel) : 8'h00;
        busy_d   = (busy_q & ~busy_clr) | busy_set;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_q <= 8'h00;
        end else if (i_en) begin
            busy_q <= busy_d;
        end
    end

    assign q_busy = busy_q;
`else
    logic unused_claim;
    assign unused_claim = ^{i_claim, i_claim_sel};
    assign q_busy       = 8'h00;
    assign q_stall      = 1'b0;
`endif

endmodule

// File: tb/tb_prco_reg_arb.sv
module tb_prco_reg_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  req;
    logic [2:0]  sel0, sel1, sel2;
    logic [15:0] dat0, dat1, dat2;
    logic [2:0]  gnt;
    logic        we;
    logic [2:0]  seld;
    logic [15:0] datd;
    logic        claim;
    logic [2:0]  claim_sel;
    logic [7:0]  busy;
    logic        stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prco_reg_arb dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_req       (req),
        .i_sel0      (sel0),
        .i_sel1      (sel1),
        .i_sel2      (sel2),
        .i_dat0      (dat0),
        .i_dat1      (dat1),
        .i_dat2      (dat2),
        .q_gnt       (gnt),
        .q_we        (we),
        .q_seld      (seld),
        .q_datd      (datd),
        .i_claim     (claim),
        .i_claim_sel (claim_sel),
        .q_busy      (busy),
        .q_stall     (stall)
    );

    // Reference model: pointer to the last winner, the previous grant, write-port outputs,
    // and one bit per register for pending writes.
    int          m_last;
    logic [2:0]  m_gnt;
    logic        m_we;
    logic [2:0]  m_seld;
    logic [15:0] m_datd;
    bit          m_busy [8];

    function automatic logic [7:0] model_busy();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic model_stall();
`ifdef PRCO_ARB_SCOREBOARD_EN
        return claim && m_busy[claim_sel];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_last = 2;
        m_gnt  = 3'b000;
        m_we   = 1'b0;
        m_seld = 3'd0;
        m_datd = 16'h0000;
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    endtask

    // Advance the model by one clock edge, using the inputs as they are just before that edge.
    task automatic model_edge();
        int win = -1;
        int idx;
        if (!en) begin
            m_gnt = 3'b000;
            m_we  = 1'b0;
            return;
        end
`ifdef PRCO_ARB_SCOREBOARD_EN
        begin
            bit st;
            st = model_stall();
            if (m_we) m_busy[m_seld] = 1'b0;
            if (claim && !st) m_busy[claim_sel] = 1'b1;
        end
`endif
        for (int k = 1; k <= 3; k++) begin
            idx = (m_last + k) % 3;
            if (win < 0 && req[idx] && !m_gnt[idx]) win = idx;
        end
        if (win >= 0) begin
            m_gnt  = 3'(1 << win);
            m_we   = 1'b1;
            m_seld = (win == 0) ? sel0 : (win == 1) ? sel1 : sel2;
            m_datd = (win == 0) ? dat0 : (win == 1) ? dat1 : dat2;
            m_last = win;
        end else begin
            m_gnt = 3'b000;
            m_we  = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; req = 3'b000; claim = 1'b0; claim_sel = 3'd0;
        sel0 = 3'd0; sel1 = 3'd0; sel2 = 3'd0;
        dat0 = 16'h0; dat1 = 16'h0; dat2 = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({gnt, we, seld, datd, busy} !== {3'b000, 1'b0, 3'd0, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: gnt=%b we=%b seld=%0d datd=%h busy=%h, want all zero",
                     gnt, we, seld, datd, busy);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_priority();
        logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] exp_s [4] = '{3'd1, 3'd2, 3'd6, 3'd1};
        logic [15:0] exp_d [4] = '{16'hAAAA, 16'h5555, 16'h1234, 16'hAAAA};
        do_reset();
        sel0 = 3'd1; sel1 = 3'd2; sel2 = 3'd6;
        dat0 = 16'hAAAA; dat1 = 16'h5555; dat2 = 16'h1234;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({gnt, we, seld, datd} !== {exp_g[i], 1'b1, exp_s[i], exp_d[i]}) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%b we=%b seld=%0d datd=%h, want %b 1 %0d %h",
                         i, gnt, we, seld, datd, exp_g[i], exp_s[i], exp_d[i]);
            end
        end
        req = 3'b000;
        tick();
        checks++;
        if ({gnt, we, seld, datd} !== {3'b000, 1'b0, 3'd1, 16'hAAAA}) begin
            errors++;
            $display("FAIL idle_hold: gnt=%b we=%b seld=%0d datd=%h, want 000 0 1 aaaa",
                     gnt, we, seld, datd);
        end
    endtask

    task automatic test_single_write();
        req = 3'b010; sel1 = 3'd3; dat1 = 16'hBEEF;
        tick();
        req = 3'b000;
        checks++;
        if ({gnt, we, seld, datd} !== {3'b010, 1'b1, 3'd3, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_write: gnt=%b we=%b seld=%0d datd=%h, want 010 1 3 beef",
                     gnt, we, seld, datd);
        end
        tick();
        checks++;
        if ({gnt, we, seld, datd} !== {3'b000, 1'b0, 3'd3, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_write_end: gnt=%b we=%b seld=%0d datd=%h, want 000 0 3 beef",
                     gnt, we, seld, datd);
        end
    endtask

    task automatic test_enable();
        do_reset();
        sel0 = 3'd4; sel1 = 3'd5; sel2 = 3'd7;
        dat0 = 16'h1000; dat1 = 16'h2000; dat2 = 16'h3000;
        req = 3'b111;
        tick();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL en_first: gnt=%b, want 001", gnt);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({gnt, we, seld, datd} !== {3'b000, 1'b0, 3'd4, 16'h1000}) begin
                errors++;
                $display("FAIL en_hold[%0d]: gnt=%b we=%b seld=%0d datd=%h, want 000 0 4 1000",
                         i, gnt, we, seld, datd);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({gnt, we, seld, datd} !== {3'b010, 1'b1, 3'd5, 16'h2000}) begin
            errors++;
            $display("FAIL en_resume: gnt=%b we=%b seld=%0d datd=%h, want 010 1 5 2000",
                     gnt, we, seld, datd);
        end
        tick();
        checks++;
        if (gnt !== 3'b100) begin
            errors++;
            $display("FAIL en_resume2: gnt=%b, want 100", gnt);
        end
        req = 3'b000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b111; claim = 1'b1; claim_sel = 3'd2;
        tick();
        claim = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({gnt, we, busy} !== {3'b000, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: gnt=%b we=%b busy=%h, want 000 0 00", gnt, we, busy);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, we} !== {3'b001, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_next: gnt=%b we=%b, want 001 1", gnt, we);
        end
        req = 3'b000;
    endtask

    task automatic test_scoreboard();
        logic [7:0] b1;
        logic       s1;
`ifdef PRCO_ARB_SCOREBOARD_EN
        b1 = 8'h20; s1 = 1'b1;
`else
        b1 = 8'h00; s1 = 1'b0;
`endif
        do_reset();
        claim = 1'b1; claim_sel = 3'd5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_first_stall: stall=%b, want 0", stall);
        end
        tick();
        checks++;
        if (busy !== b1) begin
            errors++;
            $display("FAIL sb_claim: busy=%h, want %h", busy, b1);
        end
        #1;
        checks++;
        if (stall !== s1) begin
            errors++;
            $display("FAIL sb_second_stall: stall=%b, want %b", stall, s1);
        end
        tick();
        claim = 1'b0;
        req = 3'b001; sel0 = 3'd5; dat0 = 16'h0F0F;
        tick();
        req = 3'b000;
        checks++;
        if ({we, seld, busy} !== {1'b1, 3'd5, b1}) begin
            errors++;
            $display("FAIL sb_write: we=%b seld=%0d busy=%h, want 1 5 %h", we, seld, busy, b1);
        end
        tick();
        checks++;
        if ({busy, stall} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL sb_clear: busy=%h stall=%b, want 00 0", busy, stall);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            req       = 3'($urandom_range(0, 7));
            sel0      = 3'($urandom_range(0, 7));
            sel1      = 3'($urandom_range(0, 7));
            sel2      = 3'($urandom_range(0, 7));
            dat0      = 16'($urandom);
            dat1      = 16'($urandom);
            dat2      = 16'($urandom);
            claim     = 1'($urandom_range(0, 1));
            claim_sel = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (stall !== model_stall()) begin
                errors++;
                $display("FAIL rand_stall[%0d]: stall=%b, want %b", c, stall, model_stall());
            end
            tick();
            checks++;
            if ({gnt, we, seld, datd} !== {m_gnt, m_we, m_seld, m_datd}) begin
                errors++;
                $display("FAIL rand_port[%0d]: gnt=%b we=%b seld=%0d datd=%h, want %b %b %0d %h",
                         c, gnt, we, seld, datd, m_gnt, m_we, m_seld, m_datd);
            end
            checks++;
            if (busy !== model_busy()) begin
                errors++;
                $display("FAIL rand_busy[%0d]: busy=%h, want %h", c, busy, model_busy());
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_reset_priority();
        test_single_write();
        test_enable();
        test_async_reset();
        test_scoreboard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
